lpif_dstrm_arb_ctrl: RTL and testbench

Downstream channel scheduler for the LPIF x4 asym2 half-rate master. It shares the single `dstrm_*` user channel between NUM_REQ protocol stacks using round-robin arbitration. Issue is gated by `tx_online` and by a downstream flit-credit counter. It sits in front of the master top's `dstrm_*` inputs and drives every one of them from registers.

---
 rtl/lpif_arb_pkg.sv | 26 ++
 rtl/lpif_rr_arb.sv | 36 +++
 rtl/lpif_dstrm_arb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lpif_dstrm_arb_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lpif_arb_pkg.sv
// Shared types and constants for the LPIF downstream channel scheduler.
// Optional build macro: LPIF_DSTRM_ARB_PKT_LOCK_EN (packet lock in the top).
package lpif_arb_pkg;
  localparam int LPIF_DATA_W   = 128;
  localparam int LPIF_PROTID_W = 4;
  localparam int LPIF_IDX_W    = 3;   // enough for up to 8 requesters

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    ARB     = 2'd1,
    XFER    = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [LPIF_PROTID_W-1:0] protid;
    logic [LPIF_DATA_W-1:0]   data;
    logic [1:0]               dvalid;
    logic [7:0]               crc;
    logic [1:0]               crc_valid;
  } dstrm_flit_t;

  // Round-robin successor: idx+1 wrapping at n.
  function automatic logic [LPIF_IDX_W-1:0] rr_next(input logic [LPIF_IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + LPIF_IDX_W'(1);
  endfunction
endpackage

// File: rtl/lpif_rr_arb.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping to the lowest-numbered requester.
module lpif_rr_arb
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [LPIF_IDX_W-1:0] i_ptr,
  input  logic                  i_en,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic [LPIF_IDX_W-1:0] o_idx
);
  logic w_found;

  // Two passes: upper window from the pointer first, then wrap from 0.
  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k] && (k >= int'(i_ptr))) begin
        w_found = 1'b1;
        o_idx   = LPIF_IDX_W'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        w_found = 1'b1;
        o_idx   = LPIF_IDX_W'(k);
      end
    end
    o_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++)
      o_gnt[k] = i_en && w_found && (o_idx == LPIF_IDX_W'(k));
  end
endmodule

// File: rtl/lpif_dstrm_arb_ctrl.sv
// Downstream channel scheduler: shares the dstrm_* channel between NUM_REQ
// stacks with round-robin arbitration, gated by tx_online and flit credits.
// Build macro LPIF_DSTRM_ARB_PKT_LOCK_EN: hold the grant for a whole packet.
module lpif_dstrm_arb_ctrl
  import lpif_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CREDIT_W = 8
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  input  logic                      tx_online,
  input  logic [CREDIT_W-1:0]       init_downstream_credit,
  input  logic                      credit_return,
  input  logic [7:0]                lp_state,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*4-1:0]      req_protid,
  input  logic [NUM_REQ*128-1:0]    req_data,
  input  logic [NUM_REQ*2-1:0]      req_dvalid,
  input  logic [NUM_REQ*8-1:0]      req_crc,
  input  logic [NUM_REQ*2-1:0]      req_crc_valid,
  output logic [7:0]                dstrm_state,
  output logic [3:0]                dstrm_protid,
  output logic [127:0]              dstrm_data,
  output logic [1:0]                dstrm_dvalid,
  output logic [7:0]                dstrm_crc,
  output logic [1:0]                dstrm_crc_valid,
  output logic [1:0]                dstrm_valid,
  output logic [31:0]               debug_status
);
`ifdef LPIF_DSTRM_ARB_PKT_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
`else
  localparam bit PKT_LOCK = 1'b0;
`endif

  arb_state_e              r_state, w_state_nxt;
  logic [CREDIT_W-1:0]     r_credit;
  logic                    r_ovf;
  logic [LPIF_IDX_W-1:0]   r_ptr, r_grant, w_arb_idx, w_sel;
  logic [NUM_REQ-1:0]      w_arb_gnt;
  logic                    w_credit_ok, w_arb_en, w_hs, w_last;
  dstrm_flit_t             w_flit, r_flit;

  assign w_credit_ok = |r_credit;
  assign w_arb_en    = tx_online && w_credit_ok && (r_state == ARB);
  assign w_sel       = (r_state == XFER) ? r_grant : w_arb_idx;
  assign w_hs        = |req_ready;   // ready is only ever raised on a valid requester

  lpif_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  // State register
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_state <= OFFLINE;
    else           r_state <= w_state_nxt;
  end

  // Next-state: link loss wins from any state; lock only with the macro
  always_comb begin
    w_state_nxt = r_state;
    if (!tx_online) w_state_nxt = OFFLINE;
    else begin
      case (r_state)
        OFFLINE: w_state_nxt = ARB;
        ARB:     if (w_hs && PKT_LOCK && !w_last) w_state_nxt = XFER;
        XFER:    if (w_hs && w_last) w_state_nxt = ARB;
        default: w_state_nxt = OFFLINE;
      endcase
    end
  end

  // Ready: arbiter grant in ARB, locked requester only in XFER
  always_comb begin
    req_ready = '0;
    case (r_state)
      ARB:  req_ready = w_arb_gnt;
      XFER: for (int k = 0; k < NUM_REQ; k++)
              req_ready[k] = tx_online && w_credit_ok && req_valid[k] &&
                             (r_grant == LPIF_IDX_W'(k));
      default: req_ready = '0;
    endcase
  end

  // Flit mux on the selected requester
  always_comb begin
    w_flit = '0;
    w_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel == LPIF_IDX_W'(k)) begin
        w_flit.protid    = req_protid[k*4 +: 4];
        w_flit.data      = req_data[k*128 +: 128];
        w_flit.dvalid    = req_dvalid[k*2 +: 2];
        w_flit.crc       = req_crc[k*8 +: 8];
        w_flit.crc_valid = req_crc_valid[k*2 +: 2];
        w_last           = req_last[k];
      end
    end
  end

  // Credit counter: load on link-up, saturate with sticky overflow
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_credit <= '0;
      r_ovf    <= 1'b0;
    end else if (!tx_online) begin
      r_credit <= '0;
    end else if (r_state == OFFLINE) begin
      r_credit <= init_downstream_credit;
    end else if (w_hs && !credit_return) begin
      r_credit <= r_credit - CREDIT_W'(1);
    end else if (!w_hs && credit_return) begin
      if (&r_credit) r_ovf    <= 1'b1;
      else           r_credit <= r_credit + CREDIT_W'(1);
    end
  end

  // Grant and pointer move only when a new winner is picked in ARB
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_hs && (r_state == ARB)) begin
      r_grant <= w_arb_idx;
      r_ptr   <= rr_next(w_arb_idx, NUM_REQ);
    end
  end

  // Output register: flit fields are zero on idle cycles
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      dstrm_state <= '0;
      r_flit      <= '0;
      dstrm_valid <= 2'b00;
    end else begin
      dstrm_state <= lp_state;
      r_flit      <= w_hs ? w_flit : '0;
      dstrm_valid <= {2{w_hs}};
    end
  end

  assign dstrm_protid    = r_flit.protid;
  assign dstrm_data      = r_flit.data;
  assign dstrm_dvalid    = r_flit.dvalid;
  assign dstrm_crc       = r_flit.crc;
  assign dstrm_crc_valid = r_flit.crc_valid;

  // Debug word assembled from live registers
  always_comb begin
    debug_status                 = '0;
    debug_status[CREDIT_W-1:0]   = r_credit;
    debug_status[8]              = r_ovf;
    debug_status[10:9]           = r_state;
    debug_status[18:16]          = r_grant;
  end
endmodule

// File: tb/tb_lpif_dstrm_arb_ctrl.sv
// Directed table-driven bench for lpif_dstrm_arb_ctrl (NUM_REQ=2, CREDIT_W=8).
module tb_lpif_dstrm_arb_ctrl;
`ifdef LPIF_DSTRM_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         clk_wr = 1'b0;
  logic         rst_wr_n;
  logic         tx_online, credit_return;
  logic [7:0]   init_downstream_credit, lp_state;
  logic [1:0]   req_valid, req_ready, req_last;
  logic [7:0]   req_protid;
  logic [255:0] req_data;
  logic [3:0]   req_dvalid, req_crc_valid;
  logic [15:0]  req_crc;
  logic [7:0]   dstrm_state;
  logic [3:0]   dstrm_protid;
  logic [127:0] dstrm_data;
  logic [1:0]   dstrm_dvalid, dstrm_crc_valid, dstrm_valid;
  logic [7:0]   dstrm_crc;
  logic [31:0]  debug_status;

  always #5 clk_wr = ~clk_wr;

  lpif_dstrm_arb_ctrl #(.NUM_REQ(2), .CREDIT_W(8)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(tx_online),
    .init_downstream_credit(init_downstream_credit), .credit_return(credit_return),
    .lp_state(lp_state), .req_valid(req_valid), .req_ready(req_ready),
    .req_last(req_last), .req_protid(req_protid), .req_data(req_data),
    .req_dvalid(req_dvalid), .req_crc(req_crc), .req_crc_valid(req_crc_valid),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .debug_status(debug_status)
  );

  // Expected issued flits of requester 0 (protid 1) and requester 1 (protid 2)
  localparam logic [143:0] F0 = {4'h1, {16{8'hA0}}, 2'b11, 8'h5A, 2'b01};
  localparam logic [143:0] F1 = {4'h2, {16{8'hB1}}, 2'b11, 8'hC3, 2'b10};

  typedef struct {
    bit         rst;
    logic       tx;
    logic [7:0] init;
    logic       ret;
    logic [1:0] vld, last, rdy;
    logic       v;
    logic [3:0] pid;
    logic [7:0] cred;
    logic       ovf;
    logic [1:0] st;
    logic [2:0] gnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(bit rst, logic tx, logic [7:0] init, logic ret,
                              logic [1:0] vld, logic [1:0] last, logic [1:0] rdy,
                              logic v, logic [3:0] pid, logic [7:0] cred, logic ovf,
                              logic [1:0] st, logic [2:0] gnt);
    vec_t r;
    r.rst = rst; r.tx = tx; r.init = init; r.ret = ret; r.vld = vld; r.last = last;
    r.rdy = rdy; r.v = v; r.pid = pid; r.cred = cred; r.ovf = ovf; r.st = st; r.gnt = gnt;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_wr_n = 1'b0;
    repeat (2) @(posedge clk_wr);
    #2 rst_wr_n = 1'b1;
  endtask

  function automatic logic [143:0] exp_flit(input logic v, input logic [3:0] pid);
    if (!v)            return '0;
    else if (pid == 1) return F0;
    else               return F1;
  endfunction

  initial begin
    vec_t r;
    logic [143:0] act_flit;

    rst_wr_n = 1'b0; tx_online = 1'b0; credit_return = 1'b0;
    init_downstream_credit = 8'd0; lp_state = 8'h77;
    req_valid = 2'b00; req_last = 2'b00;
    req_protid = {4'h2, 4'h1};
    req_data = {{16{8'hB1}}, {16{8'hA0}}};
    req_dvalid = 4'b1111;
    req_crc = {8'hC3, 8'h5A};
    req_crc_valid = {2'b10, 2'b01};

    // Reset state: everything zero even with lp_state driven
    repeat (2) @(posedge clk_wr);
    #1;
    chk("reset_valid", -1, 256'(dstrm_valid), 256'(0));
    chk("reset_state", -1, 256'(dstrm_state), 256'(0));
    chk("reset_flit", -1, 256'({dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid}), 256'(0));
    chk("reset_debug", -1, 256'(debug_status), 256'(0));
    chk("reset_ready", -1, 256'(req_ready), 256'(0));
    #1;

    // 3 credits, requester 0 offers single-flit packets; then one credit return
    tbl.push_back(mk(1, 1, 3, 0, 2'b01, 2'b01, 2'b00, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b01, 1, 1, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b01, 1, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b01, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 1, 2'b01, 2'b01, 2'b00, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b01, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0));
    // Both requesters continuously valid: alternate starting with 0
    tbl.push_back(mk(1, 1, 8, 0, 2'b11, 2'b11, 2'b00, 0, 0, 8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b11, 2'b01, 1, 1, 7, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b11, 2'b10, 1, 2, 6, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b11, 2'b01, 1, 1, 5, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b11, 2'b10, 1, 2, 4, 0, 1, 1));
    // Requester 1 sends a 3-flit packet while requester 0 is valid
    tbl.push_back(mk(1, 1, 8, 0, 2'b00, 2'b00, 2'b00, 0, 0, 8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b10, 2'b00, 2'b10, 1, 2, 7, 0, LOCK ? 2'd2 : 2'd1, 1));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b00, LOCK ? 2'b10 : 2'b01, 1, LOCK ? 4'd2 : 4'd1,
                     6, 0, LOCK ? 2'd2 : 2'd1, LOCK ? 3'd1 : 3'd0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b10, 2'b10, 1, 2, 5, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8, 0, 2'b11, 2'b00, 2'b01, 1, 1, 4, 0, LOCK ? 2'd2 : 2'd1, 0));
    // Saturation at 255: issue+return holds, return alone sets sticky overflow
    tbl.push_back(mk(1, 1, 255, 0, 2'b00, 2'b11, 2'b00, 0, 0, 255, 0, 1, 0));
    tbl.push_back(mk(0, 1, 255, 1, 2'b01, 2'b11, 2'b01, 1, 1, 255, 0, 1, 0));
    tbl.push_back(mk(0, 1, 255, 1, 2'b00, 2'b11, 2'b00, 0, 0, 255, 1, 1, 0));
    tbl.push_back(mk(0, 1, 255, 0, 2'b01, 2'b11, 2'b01, 1, 1, 254, 1, 1, 0));
    // Link drop mid-packet, then re-assert with 2 credits from saved pointer
    tbl.push_back(mk(1, 1, 8, 0, 2'b00, 2'b00, 2'b00, 0, 0, 8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b01, 2'b00, 2'b01, 1, 1, 7, 0, LOCK ? 2'd2 : 2'd1, 0));
    tbl.push_back(mk(0, 0, 8, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 0, 2'b11, 2'b11, 2'b00, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 2, 0, 2'b11, 2'b11, 2'b10, 1, 2, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 2, 0, 2'b11, 2'b11, 2'b01, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 2, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      r = tbl[i];
      tx_online = r.tx; init_downstream_credit = r.init; credit_return = r.ret;
      req_valid = r.vld; req_last = r.last;
      if (r.rst) do_reset();
      #1;
      chk("ready", i, 256'(req_ready), 256'(r.rdy));
      @(posedge clk_wr);
      #1;
      act_flit = {dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid};
      chk("dstrm_valid", i, 256'(dstrm_valid), 256'(r.v ? 2'b11 : 2'b00));
      chk("flit", i, 256'(act_flit), 256'(exp_flit(r.v, r.pid)));
      chk("credit", i, 256'(debug_status[7:0]), 256'(r.cred));
      chk("overflow", i, 256'(debug_status[8]), 256'(r.ovf));
      chk("fsm_state", i, 256'(debug_status[10:9]), 256'(r.st));
      chk("grant", i, 256'(debug_status[18:16]), 256'(r.gnt));
      chk("debug_zero", i, 256'({debug_status[31:19], debug_status[15:11]}), 256'(0));
      #1;
    end

    // lp_state forwarded with one cycle of delay while offline
    tx_online = 1'b0; req_valid = 2'b11; lp_state = 8'h3C;
    @(posedge clk_wr); #1;
    chk("lp_state_fwd", 100, 256'(dstrm_state), 256'(8'h3C));
    chk("offline_st", 100, 256'(debug_status[10:9]), 256'(0));
    #1 lp_state = 8'hA5;
    #1;
    chk("offline_ready", 101, 256'(req_ready), 256'(0));
    chk("lp_state_hold", 101, 256'(dstrm_state), 256'(8'h3C));
    @(posedge clk_wr); #1;
    chk("lp_state_next", 101, 256'(dstrm_state), 256'(8'hA5));
    chk("offline_valid", 101, 256'(dstrm_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
